// File: rtl/fifo_pkg.sv
// Shared defaults and depth helper for the FIFO pointer/flag controller.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_AF_LEVEL   = 14;
  localparam int DEF_AE_LEVEL   = 2;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_wrap_cnt.sv
// Wrapping address counter: advances on enable, synchronous clear, async reset.
module fifo_wrap_cnt
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic                  clr_i,
  output logic [ADDR_WIDTH-1:0] cnt_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_C = ADDR_WIDTH'(depth_of(ADDR_WIDTH) - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_C  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + ONE_C;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_ptr_flags.sv
// FIFO pointer and status-flag controller for an external dual-port RAM.
module fifo_ptr_flags
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = DEF_AF_LEVEL,
  parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  wr_ack,
  output logic                  rd_ack,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth_of(ADDR_WIDTH));
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          af_q, af_d, ae_q, ae_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;

  // Acks are gated by reset so the RAM never sees a write strobe while held in reset.
  assign rd_ack = rd & ~empty_q & ~flush & ~reset;
  assign wr_ack = wr & ~flush & (~full_q | rd) & ~reset;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (wr_ack && !rd_ack) begin
      count_d = count_q + ONE_C;
    end else if (rd_ack && !wr_ack) begin
      count_d = count_q - ONE_C;
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    ovf_d   = wr & ~wr_ack & ~flush;
    udf_d   = rd & ~rd_ack & ~flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_wrap_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (wr_ack),
    .clr_i (flush),
    .cnt_o (w_addr)
  );

  fifo_wrap_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (rd_ack),
    .clr_i (flush),
    .cnt_o (r_addr)
  );

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
